// File: rtl/fb_arb_pkg.sv
// rtl/fb_arb_pkg.sv - shared types and defaults for the frame-buffer arbiter
package fb_arb_pkg;

  localparam int ADDR_W_DEF = 18;
  localparam int DATA_W_DEF = 24;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    VGA    = 2'd1,
    CPU_RD = 2'd2
  } owner_t;

  typedef enum logic [1:0] {
    C_IDLE    = 2'd0,
    C_WAIT    = 2'd1,
    C_RD_PEND = 2'd2,
    C_DONE    = 2'd3
  } cpu_st_t;

endpackage

// File: rtl/retardo_owner.sv
// rtl/retardo_owner.sv - owner tag delay line matching the RAM read latency
module retardo_owner
  import fb_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  owner_t din,
  output owner_t dout
);

  owner_t pipe [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= NONE;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/arbitro_framebuffer.sv
// rtl/arbitro_framebuffer.sv - single-port frame-buffer arbiter, VGA fetch vs CPU port
module arbitro_framebuffer
  import fb_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RD_LAT     = 1,
  parameter int MAX_STARVE = 8
) (
  input  logic              clock_25,
  input  logic              reset,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_data,
  output logic              vga_valid,
  output logic              vga_miss,
  output logic [15:0]       vga_underrun,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int STARVE_W = $clog2(MAX_STARVE + 1);

  cpu_st_t             cpu_st, cpu_st_nxt;
  logic [STARVE_W-1:0] starve_cnt;
  logic                force_cpu, vga_gnt, cpu_gnt;
  owner_t              tag_in, tag_out;

  // VGA wins every slot unless the CPU has waited long enough to be pushed through
  always_comb begin
    force_cpu = (cpu_st == C_WAIT) && (starve_cnt == STARVE_W'(MAX_STARVE - 1));
    vga_gnt   = vga_req && !force_cpu;
    cpu_gnt   = !vga_gnt && (cpu_st == C_WAIT);
    tag_in    = NONE;
    if (vga_gnt)                tag_in = VGA;
    else if (cpu_gnt && !cpu_we) tag_in = CPU_RD;
  end

  always_comb begin
    cpu_st_nxt = cpu_st;
    case (cpu_st)
      C_IDLE:    if (cpu_req) cpu_st_nxt = C_WAIT;
      C_WAIT:    if (cpu_gnt) cpu_st_nxt = cpu_we ? C_DONE : C_RD_PEND;
      C_RD_PEND: if (tag_out == CPU_RD) cpu_st_nxt = C_DONE;
      C_DONE:    cpu_st_nxt = C_IDLE;
      default:   cpu_st_nxt = C_IDLE;
    endcase
  end

  always_ff @(posedge clock_25 or posedge reset) begin
    if (reset) begin
      cpu_st     <= C_IDLE;
      starve_cnt <= '0;
    end else begin
      cpu_st <= cpu_st_nxt;
      if (cpu_st == C_IDLE)
        starve_cnt <= '0;
      else if ((cpu_st == C_WAIT) && !cpu_gnt)
        starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end

  retardo_owner #(.DEPTH(RD_LAT + 1)) u_retardo_owner (
    .clk  (clock_25),
    .rst  (reset),
    .din  (tag_in),
    .dout (tag_out)
  );

  always_ff @(posedge clock_25 or posedge reset) begin
    if (reset) begin
      vga_data     <= '0;
      vga_valid    <= 1'b0;
      vga_miss     <= 1'b0;
      vga_underrun <= '0;
      cpu_ack      <= 1'b0;
      cpu_rdata    <= '0;
      mem_addr     <= '0;
      mem_we       <= 1'b0;
      mem_wdata    <= '0;
    end else begin
      vga_valid <= 1'b0;
      vga_miss  <= 1'b0;
      cpu_ack   <= 1'b0;
      mem_we    <= 1'b0;

      if (vga_gnt) begin
        mem_addr <= vga_addr;
      end else if (cpu_gnt) begin
        mem_addr  <= cpu_addr;
        mem_we    <= cpu_we;
        mem_wdata <= cpu_wdata;
        if (cpu_we) cpu_ack <= 1'b1;
      end

      // a VGA request displaced by starvation relief is lost, not retried
      if (force_cpu && vga_req) begin
        vga_miss <= 1'b1;
        if (vga_underrun != 16'hFFFF) vga_underrun <= vga_underrun + 16'd1;
      end

      case (tag_out)
        VGA: begin
          vga_data  <= mem_rdata;
          vga_valid <= 1'b1;
        end
        CPU_RD: begin
          cpu_rdata <= mem_rdata;
          cpu_ack   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
